// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, synchronous instruction-memory requests and a small
// instruction queue that absorbs decoder back-pressure; redirects flush all fetched work.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        dec_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 2;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     data_q [DEPTH];
    logic [31:0]     qpc_q  [DEPTH];

    logic            valid_s;
    logic            pop_s;
    logic            push_s;
    logic            req_s;
    logic [CW-1:0]   occ_s;

    // Head-of-queue presentation, zeroed when the queue is empty
    always_comb begin
        valid_s = (count_q != {CW{1'b0}});
        if (valid_s) begin
            instr_o    = data_q[rd_ptr_q];
            instr_pc_o = qpc_q[rd_ptr_q];
        end else begin
            instr_o    = 32'h0000_0000;
            instr_pc_o = 32'h0000_0000;
        end
    end

    // Request gating: slots already promised (queued + in flight) after this cycle's pop
    always_comb begin
        pop_s  = valid_s & dec_ready_i;
        push_s = inflight_q & ~redirect_valid_i;
        occ_s  = count_q + CW'(inflight_q) - CW'(pop_s);
        req_s  = (state_q == ST_RUN) && !redirect_valid_i && (occ_s < CW'(DEPTH));
    end

    assign imem_req_o    = req_s;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_s;

    // Next-state logic for control state, PC, in-flight tracking and queue pointers
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
        if (redirect_valid_i) begin
            // Response arriving now belongs to the abandoned path and is dropped
            pc_d     = redirect_pc_i & 32'hFFFF_FFFC;
            count_d  = {CW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
        end else begin
            if (req_s) begin
                pc_d          = pc_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end else begin
                inflight_d    = 1'b0;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // Control and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0000_0000;
            count_q       <= {CW{1'b0}};
            rd_ptr_q      <= {PW{1'b0}};
            wr_ptr_q      <= {PW{1'b0}};
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Queue storage: instruction word plus its PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= 32'h0000_0000;
                qpc_q[i]  <= 32'h0000_0000;
            end
        end else if (push_s) begin
            data_q[wr_ptr_q] <= imem_rdata_i;
            qpc_q[wr_ptr_q]  <= inflight_pc_q;
        end
    end

    fetch_stage_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .count_i (count_q)
    );

endmodule

// Queue occupancy invariants for fetch_stage.
module fetch_stage_chk #(
    parameter int DEPTH = 2,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push_i,
    input logic [CW-1:0] count_i
);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        push_i |-> (count_i < CW'(DEPTH)));

    a_count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        count_i <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        dec_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_infl;
    logic [31:0] m_infl_pc;
    bit          m_run;
    bit          e_pop;
    bit          e_req;
    bit          cur_rv;
    logic [31:0] cur_rpc;
    // Memory environment: answers whatever the DUT actually requested
    bit          env_pend;
    logic [31:0] env_addr;

    fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_o       (imem_req),
        .imem_addr_o      (imem_addr),
        .imem_rdata_i     (imem_rdata),
        .dec_ready_i      (dec_ready),
        .instr_valid_o    (instr_valid),
        .instr_o          (instr),
        .instr_pc_o       (instr_pc),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_f = 32'h0050_0017;
            32'h0000_0004: mem_f = 32'h0000_0038;
            32'h0000_0010: mem_f = 32'h0000_003E;
            32'h0000_0014: mem_f = 32'h0000_083D;
            default:       mem_f = a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    // Apply inputs for this cycle (called at negedge) and compare against the model
    task automatic drive(input bit rdy, input bit rv, input logic [31:0] rpc);
        bit e_valid;
        cur_rv         = rv;
        cur_rpc        = rpc;
        dec_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_rdata     = env_pend ? mem_f(env_addr) : 32'hBAD0_BAD0;
        #1;
        e_valid = (mq.size() != 0);
        e_pop   = e_valid && rdy;
        e_req   = m_run && !rv && ((mq.size() + int'(m_infl) - int'(e_pop)) < DEPTH);
        check_eq("instr_valid", 32'(instr_valid), 32'(e_valid));
        check_eq("instr", instr, e_valid ? mq[0].data : 32'h0);
        check_eq("instr_pc", instr_pc, e_valid ? mq[0].pc : 32'h0);
        check_eq("imem_req", 32'(imem_req), 32'(e_req));
        check_eq("imem_addr", imem_addr, m_pc);
        check_eq("count", 32'(dut.count_q), 32'(mq.size()));
    endtask

    // Advance the model and the clock by one cycle, ending at the next negedge
    task automatic adv();
        ent_t e;
        env_pend = imem_req;
        env_addr = imem_addr;
        if (cur_rv) begin
            mq.delete();
            m_pc   = {cur_rpc[31:2], 2'b00};
            m_infl = 1'b0;
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (m_infl) begin
                e.data = mem_f(m_infl_pc);
                e.pc   = m_infl_pc;
                mq.push_back(e);
            end
            if (e_req) begin
                m_infl    = 1'b1;
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end else begin
                m_infl = 1'b0;
            end
        end
        m_run = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once
    task automatic apply_reset();
        #2;
        rst_n          = 1'b0;
        dec_ready      = 1'b1;
        redirect_valid = 1'b0;
        imem_rdata     = 32'h0;
        #1;
        check_eq("rst_instr_valid", 32'(instr_valid), 32'h0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_instr_pc", instr_pc, 32'h0);
        check_eq("rst_imem_req", 32'(imem_req), 32'h0);
        check_eq("rst_imem_addr", imem_addr, RESET_PC);
        check_eq("rst_count", 32'(dut.count_q), 32'h0);
        mq.delete();
        m_pc     = RESET_PC;
        m_infl   = 1'b0;
        m_run    = 1'b0;
        env_pend = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Start-up sequence from reset release, optionally with a back-pressure window
    task automatic boot_seq(input bit with_bp);
        int last;
        last = with_bp ? 14 : 4;
        for (int c = 0; c <= last; c++) begin
            drive(!(with_bp && c >= 7 && c <= 12), 1'b0, 32'h0);
            if (c == 1) check_eq("boot_first_req", 32'(imem_req), 32'h1);
            if (c == 3) begin
                check_eq("boot_instr0", instr, 32'h0050_0017);
                check_eq("boot_pc0", instr_pc, 32'h0);
            end
            if (c == 4) begin
                check_eq("boot_instr1", instr, 32'h0000_0038);
                check_eq("boot_pc1", instr_pc, 32'h4);
            end
            if (with_bp && c == 12) begin
                check_eq("bp_full_count", 32'(dut.count_q), 32'h2);
                check_eq("bp_full_noreq", 32'(imem_req), 32'h0);
                check_eq("bp_head", instr, 32'h0000_003E);
            end
            if (with_bp && c == 14) begin
                check_eq("bp_next", instr, 32'h0000_083D);
                check_eq("bp_next_pc", instr_pc, 32'h14);
            end
            adv();
        end
    endtask

    initial begin
        logic [31:0] r;
        @(negedge clk);
        apply_reset();
        boot_seq(1'b1);

        // Redirect with a read in flight and a held-off decoder
        drive(1'b0, 1'b1, 32'h0000_0043);
        adv();
        drive(1'b1, 1'b0, 32'h0);
        check_eq("redir_addr", imem_addr, 32'h40);
        check_eq("redir_req", 32'(imem_req), 32'h1);
        check_eq("redir_v1", 32'(instr_valid), 32'h0);
        adv();
        drive(1'b1, 1'b0, 32'h0);
        check_eq("redir_v2", 32'(instr_valid), 32'h0);
        adv();
        drive(1'b1, 1'b0, 32'h0);
        check_eq("redir_pc", instr_pc, 32'h40);
        adv();

        // Steady push+pop at one entry
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0, 32'h0);
            check_eq("pp_count", 32'(dut.count_q), 32'h1);
            check_eq("pp_pc", instr_pc, 32'h40 + 32'(4 * (k + 1)));
            adv();
        end

        // PC wrap at the top of the address space
        drive(1'b1, 1'b1, 32'hFFFF_FFF8);
        adv();
        drive(1'b1, 1'b0, 32'h0);
        check_eq("wrap_addr", imem_addr, 32'hFFFF_FFF8);
        adv();
        drive(1'b1, 1'b0, 32'h0);
        adv();
        drive(1'b1, 1'b0, 32'h0);
        check_eq("wrap_pc0", instr_pc, 32'hFFFF_FFF8);
        adv();
        drive(1'b1, 1'b0, 32'h0);
        check_eq("wrap_pc1", instr_pc, 32'hFFFF_FFFC);
        adv();
        drive(1'b1, 1'b0, 32'h0);
        check_eq("wrap_pc2", instr_pc, 32'h0000_0000);
        adv();

        // Reset in the middle of traffic, then a clean restart
        apply_reset();
        boot_seq(1'b0);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom;
            if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            drive($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 6, r);
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
